// File: rtl/rotate_sequencer.sv
// Rotation select and character hold for the rotating 7-segment word display.
// Select advances on a prescaled tick while running, or on a manual step when idle.
module rotate_sequencer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] chars_in,
  output logic [1:0] s,
  output logic [1:0] u,
  output logic [1:0] v,
  output logic [1:0] w,
  output logic [1:0] x,
  output logic       tick,
  output logic       running
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_s;
  logic [1:0]    r_u;
  logic [1:0]    r_v;
  logic [1:0]    r_w;
  logic [1:0]    r_x;
  logic          r_tick;
  logic          r_running;

  logic w_stay_run;
  logic w_term;
  logic w_step;
  logic w_adv;

  // Prescaler only counts while staying in RUN; any transition clears it.
  assign w_stay_run = (r_state == RUN) && run;
  assign w_term     = w_stay_run && (r_presc == LAST);
  assign w_step     = (r_state == IDLE) && !run && step;
  assign w_adv      = (w_term || w_step) && !load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_s       <= 2'b00;
      r_u       <= 2'b00;
      r_v       <= 2'b01;
      r_w       <= 2'b10;
      r_x       <= 2'b11;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= run ? RUN : IDLE;
      r_running <= run;
      r_tick    <= w_adv;
      if (load || !w_stay_run || w_term)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;
      if (load) begin
        r_s <= 2'b00;
        r_u <= chars_in[7:6];
        r_v <= chars_in[5:4];
        r_w <= chars_in[3:2];
        r_x <= chars_in[1:0];
      end else if (w_adv) begin
        r_s <= dir ? r_s - 2'd1 : r_s + 2'd1;
      end
    end
  end

  assign s       = r_s;
  assign u       = r_u;
  assign v       = r_v;
  assign w       = r_w;
  assign x       = r_x;
  assign tick    = r_tick;
  assign running = r_running;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer with TICK_DIV=4.
// Inputs change #1 after each rising edge; outputs are checked there too.
module tb_rotate_sequencer;

  logic       clk;
  logic       resetn;
  logic       run;
  logic       dir;
  logic       step;
  logic       load;
  logic [7:0] chars_in;
  logic [1:0] s;
  logic [1:0] u;
  logic [1:0] v;
  logic [1:0] w;
  logic [1:0] x;
  logic       tick;
  logic       running;

  int n_chk;
  int n_pass;

  rotate_sequencer #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .dir      (dir),
    .step     (step),
    .load     (load),
    .chars_in (chars_in),
    .s        (s),
    .u        (u),
    .v        (v),
    .w        (w),
    .x        (x),
    .tick     (tick),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic edge_;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string tag, input int es, input int et);
    check({tag, ".s"}, int'(s), es);
    check({tag, ".tick"}, int'(tick), et);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    run      = 1'b0;
    dir      = 1'b0;
    step     = 1'b0;
    load     = 1'b0;
    chars_in = 8'h00;
    edge_;
    edge_;
    resetn = 1'b1;
    edge_;

    // perturb state, then reset mid-cycle
    load     = 1'b1;
    chars_in = 8'hE4;
    edge_;
    load = 1'b0;
    step = 1'b1;
    edge_;
    step = 1'b0;
    chk_sel("pre_rst", 1, 1);
    check("pre_rst.u", int'(u), 3);
    #2;
    resetn = 1'b0;
    #1;
    chk_sel("rst", 0, 0);
    check("rst.u", int'(u), 0);
    check("rst.v", int'(v), 1);
    check("rst.w", int'(w), 2);
    check("rst.x", int'(x), 3);
    check("rst.running", int'(running), 0);
    edge_;
    resetn = 1'b1;

    // auto-rotate upward with wrap
    run = 1'b1;
    dir = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      edge_;
      chk_sel($sformatf("auto%0d", e), (e / 4) % 4,
              (e > 0 && e % 4 == 0) ? 1 : 0);
      if (e == 0) check("auto.running", int'(running), 1);
    end

    // reverse manual steps
    run = 1'b0;
    dir = 1'b1;
    edge_;
    check("idle.running", int'(running), 0);
    chk_sel("idle", 0, 0);
    step = 1'b1;
    edge_;
    step = 1'b0;
    chk_sel("step1", 3, 1);
    edge_;
    chk_sel("step1_hold", 3, 0);
    step = 1'b1;
    edge_;
    chk_sel("b2b_a", 2, 1);
    edge_;
    chk_sel("b2b_b", 1, 1);
    edge_;
    chk_sel("b2b_c", 0, 1);
    step = 1'b0;
    edge_;
    chk_sel("b2b_end", 0, 0);

    // step ignored while running
    run = 1'b1;
    dir = 1'b0;
    edge_;
    edge_;
    step = 1'b1;
    edge_;
    step = 1'b0;
    chk_sel("run_step", 0, 0);
    edge_;
    chk_sel("run_e3", 0, 0);
    edge_;
    chk_sel("run_e4", 1, 1);
    for (int e = 5; e <= 8; e++) edge_;
    chk_sel("run_e8", 2, 1);

    // load collides with terminal count
    edge_;
    edge_;
    edge_;
    load     = 1'b1;
    chars_in = 8'hE4;
    edge_;
    load = 1'b0;
    chk_sel("ld_term", 0, 0);
    check("ld.u", int'(u), 3);
    check("ld.v", int'(v), 2);
    check("ld.w", int'(w), 1);
    check("ld.x", int'(x), 0);
    check("ld.running", int'(running), 1);
    edge_;
    edge_;
    edge_;
    chk_sel("ld_e3", 0, 0);
    edge_;
    chk_sel("ld_e4", 1, 1);

    // run drop on terminal edge, then full restart
    edge_;
    edge_;
    edge_;
    run = 1'b0;
    edge_;
    chk_sel("drop", 1, 0);
    check("drop.running", int'(running), 0);
    run = 1'b1;
    edge_;
    edge_;
    edge_;
    edge_;
    chk_sel("restart_e3", 1, 0);
    edge_;
    chk_sel("restart_e4", 2, 1);

    // load beats step in idle
    run = 1'b0;
    edge_;
    load     = 1'b1;
    step     = 1'b1;
    chars_in = 8'h1B;
    edge_;
    load = 1'b0;
    step = 1'b0;
    chk_sel("ld_step", 0, 0);
    check("ld2.u", int'(u), 0);
    check("ld2.x", int'(x), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Upstream control stage for the rotating 7-segment word display. It holds the four 2-bit character codes and produces the rotation select that the display multiplexer consumes. Both run off the board clock. The select advances by one position on a prescaled tick, or on a manual step. The multiplexer stays purely combinational; `s`, `u`, `v`, `w` and `x` connect straight to its ports.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per automatic advance; legal range 2 or more.
- `clk` in 1: single clock. All state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: level; 1 = auto-rotate, 0 = manual/idle.
- `dir` in 1: 0 = select increments, 1 = select decrements.
- `step` in 1: single-cycle synchronous pulse; advances one position when not running.
- `load` in 1: single-cycle synchronous pulse; captures `chars_in`.
- `chars_in` in 8: packed `{u,v,w,x}`, 2 bits each, `u` in [7:6].
- `s` out 2: registered rotation select to the display mux.
- `u`, `v`, `w`, `x` out 2 each: registered character codes to the display mux.
- `tick` out 1: registered; 1 for exactly the cycle in which a new `s` value first appears.
- `running` out 1: registered; 1 while in RUN state.

## Operation
- **Reset values** (asynchronous, while `resetn`=0):
  - `s`=00; `u`=00, `v`=01, `w`=10, `x`=11.
  - `tick`=0, `running`=0, state=IDLE.
  - Prescaler=0.
- **State machine**, two states:
  - IDLE: entered at reset. Moves to RUN on any edge with `run`=1.
  - RUN: moves to IDLE on any edge with `run`=0.
- **Prescaler**:
  - Width `$clog2(TICK_DIV)`; counts 0..TICK_DIV-1 only in RUN.
  - At TICK_DIV-1 it wraps to 0 and requests an advance.
  - Forced to 0 while in IDLE, and on the edge of any IDLE↔RUN transition.
- **Advance**:
  - `dir`=0: `s`←`s`+1, so 11 wraps to 00.
  - `dir`=1: `s`←`s`-1, so 00 wraps to 11.
  - `dir` is sampled on the advancing edge. Changing `dir` mid-count does not clear the prescaler.
- **Manual step**: in IDLE with `run`=0, `step`=1 causes one advance on that edge. `step` is ignored in RUN and on the edge where `run` rises.
- **Load**:
  - `load`=1 captures `chars_in` into `u`/`v`/`w`/`x`, forces `s`=00 and clears the prescaler.
  - State is unchanged: a running block keeps running.
- **Priority** on one edge: `load` > advance (tick or step).
  - If `load` coincides with a terminal count or `step`: no advance, `tick`=0, `s`=00.
- **`tick`**: set to 1 on exactly the edges that perform an advance, 0 otherwise. `s` changes on the same edge.
- **Stable outputs**: `u`/`v`/`w`/`x` change only on `load` or reset. They are never altered by rotation.
- **Reset mid-operation**: all registers return to reset values immediately, independent of `clk`. The first edge after release behaves as from IDLE.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- **`step` latency**: `step` sampled high at edge N → `s` updated and `tick`=1 after edge N, for one cycle.
- **RUN latency**:
  - `run` sampled high at edge N puts the block in RUN with prescaler=0 after edge N.
  - The first advance occurs at edge N+TICK_DIV.
  - Subsequent advances occur every TICK_DIV cycles.
- **`load` latency**: `load` at edge N → new characters and `s`=00 visible after edge N. The next automatic advance comes TICK_DIV edges later.
- **`run` falling** at edge N: no advance at edge N even if the prescaler is terminal; `s` holds its value.
- **Throughput**: one `step` per cycle is legal. Back-to-back `step` pulses advance `s` every cycle, with `tick` held high.

## Test plan
Bench uses `TICK_DIV`=4.
1. **Reset/defaults**: assert `resetn`=0 mid-cycle → `s`=00, `u`/`v`/`w`/`x`=00/01/10/11, `tick`=0 and `running`=0 immediately, before the next edge.
2. **Auto-rotate with wrap**: `run`=1, `dir`=0 for 17 cycles → `s` steps 01,10,11,00 at edges 4,8,12,16. `tick` is high exactly on those four cycles.
3. **Reverse and manual step**:
   - `run`=0, `dir`=1, one `step` pulse from `s`=00 → `s`=11 with one `tick`.
   - Then three back-to-back steps → `s`=10,01,00, with `tick` high for three cycles.
4. **Step ignored in RUN**: `run`=1, pulse `step` at prescaler=1 → no change until the terminal count. `s` advances only at the 4-cycle boundary.
5. **Load collision**: `s`=10 in RUN, `load`=1 with `chars_in`=8'b11_10_01_00 on a terminal-count edge:
   - `u`/`v`/`w`/`x`=11/10/01/00, `s`=00, `tick`=0.
   - Next advance to 01 occurs 4 cycles later.
6. **Run drop at terminal**: deassert `run` on the edge where the prescaler=3 → no advance, `running`=0, `s` held. Re-asserting `run` restarts a full 4-cycle count.
